// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package arm_mem_pkg;

    localparam int unsigned SRAM_DW       = 16;
    localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_LO = 3'd1,
        ST_RD_HI = 3'd2,
        ST_WR_LO = 3'd3,
        ST_WR_HI = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    function automatic logic is_access(input state_e s);
        return (s == ST_RD_LO) || (s == ST_RD_HI) || (s == ST_WR_LO) || (s == ST_WR_HI);
    endfunction

endpackage

// File: rtl/mem_phase_counter.sv
// Per-half access phase counter: counts 0..WAIT_CYCLES, cleared between halves.
module mem_phase_counter #(
    parameter int WAIT_CYCLES = 1,
    parameter int CW          = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    output logic [CW-1:0] cnt_d_o,
    output logic          done_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    assign cnt_d   = clear_i ? '0 : cnt_q + CW'(1);
    assign cnt_d_o = cnt_d;
    assign done_o  = (cnt_q == CW'(WAIT_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller: splits a 32-bit load/store into two 16-bit async SRAM
// accesses (low half first) and holds the pipeline via ready until done.
module mem_stage_sram_ctrl
    import arm_mem_pkg::*;
#(
    parameter int          SRAM_AW     = 18,
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_d;
    logic          cnt_clr, cnt_done;

    logic [31:0]        off;
    logic [SRAM_AW-1:0] addr_lo, addr_hi;
    logic               unused_off;

    logic [31:0]        rdata_q;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic [SRAM_DW-1:0] dq_out_q, dq_out_d;
    logic               dq_oe_q, dq_oe_d;
    logic               we_n_q, we_n_d;
    logic               oe_n_q, oe_n_d;

    // Word-aligned byte offset becomes an even half-word index; wraps modulo 2^SRAM_AW.
    assign off        = addr - BASE_ADDR;
    assign addr_lo    = {off[SRAM_AW:2], 1'b0};
    assign addr_hi    = {off[SRAM_AW:2], 1'b1};
    assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};

    mem_phase_counter #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .CW          (CW)
    ) u_phase (
        .clk     (clk),
        .rst     (rst),
        .clear_i (cnt_clr),
        .cnt_d_o (cnt_d),
        .done_o  (cnt_done)
    );

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        cnt_clr = 1'b1;
        case (state_q)
            ST_IDLE: begin
                ready = ~(mem_r_en | mem_w_en);
                if (mem_w_en) begin
                    state_d = ST_WR_LO;
                end else if (mem_r_en) begin
                    state_d = ST_RD_LO;
                end
            end
            ST_RD_LO: begin
                cnt_clr = cnt_done;
                if (cnt_done) state_d = ST_RD_HI;
            end
            ST_RD_HI: begin
                cnt_clr = cnt_done;
                if (cnt_done) state_d = ST_DONE;
            end
            ST_WR_LO: begin
                cnt_clr = cnt_done;
                if (cnt_done) state_d = ST_WR_HI;
            end
            ST_WR_HI: begin
                cnt_clr = cnt_done;
                if (cnt_done) state_d = ST_DONE;
            end
            ST_DONE: begin
                // Request still seen here belongs to the instruction just finished.
                ready   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pins are decoded from the next state/count and registered, so each pin
    // reflects the current state with no decode glitch (notably on we_n).
    always_comb begin
        sram_addr_d = '0;
        dq_out_d    = '0;
        dq_oe_d     = 1'b0;
        we_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        case (state_d)
            ST_RD_LO: begin
                sram_addr_d = addr_lo;
                oe_n_d      = 1'b0;
            end
            ST_RD_HI: begin
                sram_addr_d = addr_hi;
                oe_n_d      = 1'b0;
            end
            ST_WR_LO: begin
                sram_addr_d = addr_lo;
                dq_out_d    = wdata[15:0];
                dq_oe_d     = 1'b1;
                we_n_d      = (cnt_d == CW'(WAIT_CYCLES));
            end
            ST_WR_HI: begin
                sram_addr_d = addr_hi;
                dq_out_d    = wdata[31:16];
                dq_oe_d     = 1'b1;
                we_n_d      = (cnt_d == CW'(WAIT_CYCLES));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (cnt_done && is_access(state_q)) begin
            if (state_q == ST_RD_LO) rdata_q[15:0]  <= sram_dq_in;
            if (state_q == ST_RD_HI) rdata_q[31:16] <= sram_dq_in;
        end
    end

    assign rdata       = rdata_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;
    assign sram_oe_n   = oe_n_q;

endmodule
